// File: rtl/ps2_scan_sequencer_if.sv
// Bundle of PS/2 receiver-side and key-event signals between the receiver, the sequencer and the
// datapath.
interface ps2_scan_sequencer_if #(
  parameter int unsigned ERR_W = 8
);
  logic             en;
  logic [7:0]       code_in;
  logic             code_tick;
  logic             code_ok;
  logic             rx_en;
  logic [7:0]       key_code;
  logic             key_ext;
  logic             key_tick;
  logic             err_tick;
  logic [ERR_W-1:0] err_count;
  logic             held;

  modport master (
    output en, code_in, code_tick, code_ok,
    input  rx_en, key_code, key_ext, key_tick, err_tick, err_count, held
  );

  modport slave (
    input  en, code_in, code_tick, code_ok,
    output rx_en, key_code, key_ext, key_tick, err_tick, err_count, held
  );
endinterface

// File: rtl/ps2_scan_sequencer.sv
// Decodes Set-2 E0/F0 prefix sequences into single key-press events, filtering typematic
// repeats and receiver status bytes, and counting bad frames and prefix timeouts.
module ps2_scan_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 2000000,
  parameter int unsigned ERR_W          = 8
) (
  input logic                clk,
  input logic                rst,
  ps2_scan_sequencer_if.slave bus
);

  localparam int unsigned TimerW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StPfxE0, StPfxF0, StPfxE0F0} state_e;

  state_e            state_q, state_d;
  logic [TimerW-1:0] timer_q;
  logic [8:0]        held_key_q;
  logic              held_q;
  logic              rx_en_q;
  logic [7:0]        key_code_q;
  logic              key_ext_q;
  logic              key_tick_q;
  logic              err_tick_q;
  logic [ERR_W-1:0]  err_count_q;

  logic accept, bad_frame, timeout;
  logic is_make, is_break, ev_ext;
  logic [8:0] key_id;
  logic repeat_key, break_match;

  assign accept    = bus.en && bus.code_tick && bus.code_ok;
  assign bad_frame = bus.en && bus.code_tick && !bus.code_ok;
  // A byte arriving on the expiry cycle wins over the timeout.
  assign timeout   = bus.en && !bus.code_tick && (state_q != StIdle) && (timer_q == TimerLast);

  always_comb begin
    state_d  = StIdle;
    is_make  = 1'b0;
    is_break = 1'b0;
    ev_ext   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.code_in == 8'hE0) begin
          state_d = StPfxE0;
        end else if (bus.code_in == 8'hF0) begin
          state_d = StPfxF0;
        end else if (!(bus.code_in inside {8'hE1, 8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF})) begin
          is_make = 1'b1;
        end
      end
      StPfxE0: begin
        ev_ext = 1'b1;
        if (bus.code_in == 8'hF0) begin
          state_d = StPfxE0F0;
        end else if (!(bus.code_in inside {8'h12, 8'h59})) begin
          is_make = 1'b1;
        end
      end
      StPfxF0: is_break = 1'b1;
      StPfxE0F0: begin
        is_break = 1'b1;
        ev_ext   = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  assign key_id      = {ev_ext, bus.code_in};
  assign repeat_key  = held_q && (key_id == held_key_q);
  assign break_match = (key_id == held_key_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      timer_q     <= '0;
      held_key_q  <= '0;
      held_q      <= 1'b0;
      rx_en_q     <= 1'b0;
      key_code_q  <= '0;
      key_ext_q   <= 1'b0;
      key_tick_q  <= 1'b0;
      err_tick_q  <= 1'b0;
      err_count_q <= '0;
    end else begin
      rx_en_q    <= bus.en;
      key_tick_q <= 1'b0;
      err_tick_q <= 1'b0;
      if (!bus.en) begin
        state_q <= StIdle;
        held_q  <= 1'b0;
        timer_q <= '0;
      end else if (bad_frame || timeout) begin
        state_q    <= StIdle;
        timer_q    <= '0;
        err_tick_q <= 1'b1;
        if (err_count_q != '1) begin
          err_count_q <= err_count_q + 1'b1;
        end
      end else if (accept) begin
        state_q <= state_d;
        timer_q <= '0;
        if (is_make && !repeat_key) begin
          key_code_q <= bus.code_in;
          key_ext_q  <= ev_ext;
          key_tick_q <= 1'b1;
          held_key_q <= key_id;
          held_q     <= 1'b1;
        end
        if (is_break && break_match) begin
          held_q <= 1'b0;
        end
      end else if (state_q == StIdle) begin
        timer_q <= '0;
      end else begin
        timer_q <= timer_q + 1'b1;
      end
    end
  end

  assign bus.rx_en     = rx_en_q;
  assign bus.key_code  = key_code_q;
  assign bus.key_ext   = key_ext_q;
  assign bus.key_tick  = key_tick_q;
  assign bus.err_tick  = err_tick_q;
  assign bus.err_count = err_count_q;
  assign bus.held      = held_q;

endmodule

// File: tb/tb_ps2_scan_sequencer.sv
// Scoreboard bench for ps2_scan_sequencer: expected key events are queued when the completing
// byte is driven and popped by a monitor when key_tick fires.
module tb_ps2_scan_sequencer;

  localparam int unsigned TO    = 100;
  localparam int unsigned ERR_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ps2_scan_sequencer_if #(.ERR_W(ERR_W)) bus ();

  ps2_scan_sequencer #(
    .TIMEOUT_CYCLES(TO),
    .ERR_W         (ERR_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;
  logic [8:0] exp_q[$];
  int exp_err = 0;

  // Scoreboard monitor, sampling away from the active edge.
  always @(negedge clk) begin
    if (bus.key_tick) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_key: got ext=%0b code=%h, none queued", bus.key_ext, bus.key_code);
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        if ({bus.key_ext, bus.key_code} !== e) begin
          errors++;
          $display("FAIL key_event: got %h want %h", {bus.key_ext, bus.key_code}, e);
        end
      end
      checks++;
      if (bus.err_tick !== 1'b0) begin
        errors++;
        $display("FAIL tick_exclusive: err_tick=%b with key_tick", bus.err_tick);
      end
    end
  end

  task automatic send(input logic [7:0] c, input logic ok);
    bus.code_in   = c;
    bus.code_ok   = ok;
    bus.code_tick = 1'b1;
    @(posedge clk);
    #1;
    bus.code_tick = 1'b0;
  endtask

  task automatic expect_key_tick(input string name, input logic want);
    checks++;
    if (bus.key_tick !== want) begin
      errors++;
      $display("FAIL %s: key_tick=%b want %b", name, bus.key_tick, want);
    end
  endtask

  task automatic test_reset;
    bus.en = 1'b1;
    bus.code_in = 8'h00;
    bus.code_ok = 1'b1;
    bus.code_tick = 1'b0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.rx_en, bus.key_code, bus.key_ext, bus.key_tick, bus.err_tick, bus.err_count, bus.held}
        !== '0) begin
      errors++;
      $display("FAIL reset_outputs: rx_en=%b code=%h ext=%b kt=%b et=%b cnt=%h held=%b",
               bus.rx_en, bus.key_code, bus.key_ext, bus.key_tick, bus.err_tick, bus.err_count,
               bus.held);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.rx_en !== 1'b1) begin
      errors++;
      $display("FAIL rx_en_after_reset: got %b want 1", bus.rx_en);
    end
  endtask

  task automatic test_make;
    exp_q.push_back({1'b0, 8'h1C});
    send(8'h1C, 1'b1);
    expect_key_tick("make_tick", 1'b1);
    checks++;
    if (bus.key_code !== 8'h1C || bus.key_ext !== 1'b0 || bus.held !== 1'b1) begin
      errors++;
      $display("FAIL make_fields: code=%h ext=%b held=%b want 1c 0 1",
               bus.key_code, bus.key_ext, bus.held);
    end
  endtask

  task automatic test_typematic;
    repeat (3) begin
      send(8'h1C, 1'b1);
      expect_key_tick("typematic_suppressed", 1'b0);
    end
    send(8'hF0, 1'b1);
    send(8'h1C, 1'b1);
    expect_key_tick("break_no_tick", 1'b0);
    checks++;
    if (bus.held !== 1'b0) begin
      errors++;
      $display("FAIL break_held: held=%b want 0", bus.held);
    end
    exp_q.push_back({1'b0, 8'h1C});
    send(8'h1C, 1'b1);
    expect_key_tick("remake_tick", 1'b1);
    send(8'hF0, 1'b1);
    send(8'h1C, 1'b1);
  endtask

  task automatic test_extended;
    send(8'hE0, 1'b1);
    expect_key_tick("prefix_no_tick", 1'b0);
    exp_q.push_back({1'b1, 8'h75});
    send(8'h75, 1'b1);
    checks++;
    if (bus.key_code !== 8'h75 || bus.key_ext !== 1'b1 || bus.held !== 1'b1) begin
      errors++;
      $display("FAIL ext_fields: code=%h ext=%b held=%b want 75 1 1",
               bus.key_code, bus.key_ext, bus.held);
    end
    // A non-extended break of the same code must not release the extended key.
    send(8'hF0, 1'b1);
    send(8'h75, 1'b1);
    checks++;
    if (bus.held !== 1'b1) begin
      errors++;
      $display("FAIL ext_break_mismatch: held=%b want 1", bus.held);
    end
    send(8'hE0, 1'b1);
    send(8'hF0, 1'b1);
    send(8'h75, 1'b1);
    checks++;
    if (bus.held !== 1'b0) begin
      errors++;
      $display("FAIL ext_break_held: held=%b want 0", bus.held);
    end
  endtask

  task automatic test_timeout;
    send(8'hE0, 1'b1);
    for (int i = 1; i <= int'(TO); i++) begin
      @(posedge clk);
      #1;
      if (i == int'(TO) || i == int'(TO) - 1) begin
        checks++;
        if (bus.err_tick !== (i == int'(TO))) begin
          errors++;
          $display("FAIL timeout_cycle%0d: err_tick=%b want %b", i, bus.err_tick, i == int'(TO));
        end
      end
    end
    exp_err = 1;
    checks++;
    if (bus.err_count !== ERR_W'(exp_err)) begin
      errors++;
      $display("FAIL timeout_count: got %0d want %0d", bus.err_count, exp_err);
    end
    exp_q.push_back({1'b0, 8'h29});
    send(8'h29, 1'b1);
    checks++;
    if (bus.key_code !== 8'h29 || bus.key_ext !== 1'b0 || bus.key_tick !== 1'b1) begin
      errors++;
      $display("FAIL after_timeout: code=%h ext=%b tick=%b want 29 0 1",
               bus.key_code, bus.key_ext, bus.key_tick);
    end
    send(8'hF0, 1'b1);
    send(8'h29, 1'b1);
  endtask

  task automatic test_bad_frames;
    send(8'hF0, 1'b1);
    for (int i = 0; i < 256; i++) begin
      send(8'h5A, 1'b0);
      exp_err = (exp_err < 255) ? exp_err + 1 : 255;
      checks++;
      if (bus.err_tick !== 1'b1 || bus.key_tick !== 1'b0 || bus.err_count !== ERR_W'(exp_err))
      begin
        errors++;
        $display("FAIL bad_frame%0d: err_tick=%b key_tick=%b cnt=%0d want 1 0 %0d",
                 i, bus.err_tick, bus.key_tick, bus.err_count, exp_err);
      end
    end
    checks++;
    if (bus.err_count !== 8'hFF) begin
      errors++;
      $display("FAIL err_saturate: got %h want ff", bus.err_count);
    end
    exp_q.push_back({1'b0, 8'h1C});
    send(8'h1C, 1'b1);
    expect_key_tick("idle_after_bad", 1'b1);
    send(8'hF0, 1'b1);
    send(8'h1C, 1'b1);
  endtask

  task automatic test_discard;
    send(8'hAA, 1'b1);
    expect_key_tick("discard_aa", 1'b0);
    send(8'hFA, 1'b1);
    expect_key_tick("discard_fa", 1'b0);
    send(8'hE0, 1'b1);
    send(8'h12, 1'b1);
    expect_key_tick("fake_shift_12", 1'b0);
    send(8'hE0, 1'b1);
    send(8'h59, 1'b1);
    expect_key_tick("fake_shift_59", 1'b0);
  endtask

  task automatic test_enable;
    send(8'hE0, 1'b1);
    bus.en = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (bus.rx_en !== 1'b0) begin
      errors++;
      $display("FAIL rx_en_low: got %b want 0", bus.rx_en);
    end
    send(8'h3B, 1'b1);
    expect_key_tick("disabled_ignore", 1'b0);
    checks++;
    if (bus.key_code !== 8'h1C || bus.err_count !== 8'hFF || bus.err_tick !== 1'b0) begin
      errors++;
      $display("FAIL disabled_retain: code=%h cnt=%h et=%b want 1c ff 0",
               bus.key_code, bus.err_count, bus.err_tick);
    end
    bus.en = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.rx_en !== 1'b1) begin
      errors++;
      $display("FAIL rx_en_high: got %b want 1", bus.rx_en);
    end
    exp_q.push_back({1'b0, 8'h3B});
    send(8'h3B, 1'b1);
    checks++;
    if (bus.key_code !== 8'h3B || bus.key_ext !== 1'b0 || bus.key_tick !== 1'b1) begin
      errors++;
      $display("FAIL after_enable: code=%h ext=%b tick=%b want 3b 0 1",
               bus.key_code, bus.key_ext, bus.key_tick);
    end
  endtask

  task automatic test_simultaneous;
    send(8'hE0, 1'b1);
    repeat (TO - 1) @(posedge clk);
    #1;
    exp_q.push_back({1'b1, 8'h6B});
    send(8'h6B, 1'b1);
    checks++;
    if (bus.err_tick !== 1'b0 || bus.key_tick !== 1'b1 || bus.key_ext !== 1'b1) begin
      errors++;
      $display("FAIL tick_at_expiry: et=%b kt=%b ext=%b want 0 1 1",
               bus.err_tick, bus.key_tick, bus.key_ext);
    end
  endtask

  task automatic test_reset_mid;
    send(8'hE0, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({bus.rx_en, bus.key_code, bus.key_ext, bus.err_count, bus.held} !== '0) begin
      errors++;
      $display("FAIL async_reset: rx_en=%b code=%h ext=%b cnt=%h held=%b",
               bus.rx_en, bus.key_code, bus.key_ext, bus.err_count, bus.held);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    exp_q.push_back({1'b0, 8'h75});
    send(8'h75, 1'b1);
    expect_key_tick("post_reset_make", 1'b1);
  endtask

  task automatic test_drain;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d events never seen", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_make();
    test_typematic();
    test_extended();
    test_timeout();
    test_bad_frames();
    test_discard();
    test_enable();
    test_simultaneous();
    test_reset_mid();
    test_drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ps2_scan_sequencer.md
Name: ps2_scan_sequencer

Overview:
- Sits between the PS/2 frame receiver and the alarm/ventilation/display datapath.
- Consumes raw scan-code bytes (code, tick, correct) and decodes the Set-2 prefix sequences E0 (extended) and F0 (break).
- Suppresses typematic repeats and drops receiver status codes.
- Delivers exactly one clean key-press event (code plus single-cycle tick) to the datapath; also gates the receiver enable and counts frame errors and timeouts.

Parameters:
- TIMEOUT_CYCLES, 2000000, max clk cycles allowed between prefix byte and following byte (20 ms at 100 MHz).
- ERR_W, 8, width of saturating error counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  user enable; low flushes and idles the block.
- code_in  in  8  scan byte from receiver; valid only when code_tick=1.
- code_tick  in  1  one-cycle strobe, new byte available.
- code_ok  in  1  receiver parity/frame check result, qualified by code_tick.
- rx_en  out  1  enable to receiver; registered copy of en.
- key_code  out  8  make code of accepted key; held until next accepted key.
- key_ext  out  1  1 = key was E0-prefixed; held with key_code.
- key_tick  out  1  one-cycle strobe, new key_code/key_ext valid; same cycle as update.
- err_tick  out  1  one-cycle strobe on bad frame or prefix timeout.
- err_count  out  ERR_W  saturating count of err_tick events.
- held  out  1  a key is currently held down (make seen, break not yet seen).

Behaviour:
- Reset (rst=0, async): state=IDLE; rx_en=0, key_code=0, key_ext=0, key_tick=0, err_tick=0, err_count=0, held=0, held_key=0, timer=0.
- All outputs registered. key_tick asserts exactly 1 cycle after the code_tick that completes a make sequence.
- FSM states: IDLE, PFX_E0, PFX_F0, PFX_E0F0. Transitions occur only on code_tick=1 with code_ok=1 and en=1.
- IDLE:
  - E0 -> PFX_E0.
  - F0 -> PFX_F0.
  - E1, AA, FA, FE, EE, 00, FF -> discarded, stay IDLE.
  - Any other byte is a make code, ext=0.
- PFX_E0:
  - F0 -> PFX_E0F0.
  - 12 or 59 (fake shifts) -> discarded, back to IDLE.
  - Any other byte is a make code, ext=1 -> IDLE.
- PFX_F0: byte is a break code, ext=0 -> IDLE.
- PFX_E0F0: byte is a break code, ext=1 -> IDLE.
- Make handling:
  - If held=1 and {ext,code}==held_key: typematic repeat, no key_tick.
  - Otherwise: key_code<=code, key_ext<=ext, key_tick=1, held_key<={ext,code}, held<=1.
- Break handling: if {ext,code}==held_key, held<=0. Otherwise ignored. Never produces key_tick.
- Bad frame (code_tick=1, code_ok=0): err_tick=1, err_count++ (saturates at all-ones), state->IDLE. held and held_key unchanged.
- Timeout:
  - timer clears on every code_tick and increments while state!=IDLE.
  - When timer reaches TIMEOUT_CYCLES-1 without a code_tick: state->IDLE, err_tick=1, err_count++.
  - In IDLE, timer is held at 0.
- Simultaneous events: a code_tick in the same cycle as timer expiry is processed normally; the timeout is not flagged.
- en=0: rx_en<=0 next cycle; state->IDLE, held<=0, timer<=0; code_tick ignored; no key_tick/err_tick. key_code/key_ext/err_count retained.
- Reset mid-sequence: state and outputs return to reset values asynchronously; no partial key emitted.
- err_tick and key_tick never assert together (they are exclusive per byte).

Test Plan:
- Reset, en=1, send 1C ok -> key_tick 1 cycle later, key_code=1C, key_ext=0, held=1.
- Send 1C x3 then F0,1C -> no further key_tick; held=0 after break; then 1C -> key_tick again.
- Send E0,75 then E0,F0,75 -> key_code=75, key_ext=1, one key_tick; held returns 0.
- Send E0 then idle TIMEOUT_CYCLES (override to 100) -> err_tick at cycle 100, err_count=1, state IDLE; next byte 29 -> key_code=29, ext=0.
- Send byte with code_ok=0 in PFX_F0, then 255 more bad frames (ERR_W=8) -> err_count saturates at FF; FSM in IDLE after each.
- Send AA, FA, E0 12 -> no key_tick. Deassert en mid-sequence after E0, reassert, send 3B -> key_code=3B, key_ext=0; rx_en tracks en with 1-cycle lag.
